aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES-128 encryption controller: accepts one 128-bit block and runs 10 rounds on a shared
//  combinational round datapath (SubBytes/ShiftRows/MixColumns/addRoundKey), one round per clock.
//  Fetches round keys from an external synchronous key-schedule ROM. Sits between the block-level
//  valid/ready stream interface and the cipher datapath modules.
// PARAMETERS
//  NR        10  number of rounds (fixed for AES-128; other values unsupported)
//  KADDR_W   4   key-schedule address width; must satisfy 2**KADDR_W > NR
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        plaintext block offered
//  in_ready   out  1        controller idle, can accept
//  in_data    in   128      plaintext; bits[127:120]=byte0; state[r][c]=byte 4c+r
//  key_addr   out  KADDR_W  round-key index into ROM (ROM has 1-cycle read latency)
//  key_data   in   128      round key for key_addr of previous cycle
//  out_valid  out  1        ciphertext available
//  out_ready  in   1        consumer takes ciphertext
//  out_data   out  128      ciphertext, same byte order as in_data
//  busy       out  1        high in ROUND or OUT
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, key_addr=0, rnd=0, out_data=0.
//  - FSM IDLE -> ROUND -> OUT -> IDLE. One block in flight; no overlap of accept and output.
//  - IDLE: in_ready=1, key_addr held at 0, so key_data=rk[0] always valid. On in_valid&in_ready:
//    st <= in_data ^ key_data; rnd <= 1; key_addr <= 1; -> ROUND.
//  - ROUND (rnd=1..NR): key_data = rk[rnd]. st <= cipher_round(st, key_data, last=(rnd==NR));
//    last skips MixColumns. If rnd<NR: rnd++, key_addr <= rnd+1. If rnd==NR: key_addr <= 0, -> OUT.
//  - OUT: out_valid=1, out_data=st held stable until out_valid&out_ready; then -> IDLE, out_valid=0.
//  - Latency: accept at edge E0, out_valid high after edge E10 (11 cycles accept-to-valid);
//    min throughput 1 block per 12 cycles with out_ready tied high.
//  - in_valid while busy: ignored (in_ready=0); in_data must not be sampled.
//  - out_ready while not OUT: no effect. out_ready held low: stays in OUT indefinitely.
//  - rst mid-operation: abandons block, returns to reset values next edge; no partial output.
//  - All XOR/byte ops are GF(2^8), width-exact 8-bit; no carries. rnd never exceeds NR.
// CONFIGURATION
//  - Macro AES_ROUND_SEQUENCER_ABORT_EN: adds input port abort (1 bit). When defined, abort=1 in
//    ROUND or OUT forces -> IDLE next edge, out_valid=0, key_addr=0, st discarded; abort in IDLE
//    ignored; abort has priority over out_ready handshake in same cycle; rst overrides abort.
//  - Without the macro: no abort port; a started block always completes.
// STRUCTURE
//  - Shared defs header (Cipher_defs.vh): byte/state-matrix types, NR, KADDR_W, FSM state
//    encodings (IDLE/ROUND/OUT), byte-order helper functions (flat 128 <-> [4][4] bytes).
//  - One sub-module: cipher_round (combinational: SubBytes->ShiftRows->MixColumns(bypass on
//    last)->addRoundKey), built from the existing datapath modules. Controller holds FSM, rnd,
//    key_addr, st register only.
// TESTING (bench supplies key-schedule ROM model with 1-cycle latency)
//  - FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//    -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 cycles after accept.
//  - FIPS-197 App.C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff
//    -> 69c4e0d86a7b0430d8cdb78070b4c55a; key_addr sequence 0,1,..,10,0 checked per cycle.
//  - Backpressure: out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0;
//    new in_valid during this time not accepted; release -> IDLE next edge.
//  - Back-to-back: in_valid held high, out_ready=1, two App.B blocks -> both correct, 12-cycle spacing.
//  - rst asserted at rnd=5 -> next edge all outputs at reset values; following block encrypts correctly.
//  - (ABORT_EN) abort at rnd=3 -> IDLE next edge, no out_valid; abort in IDLE -> no state change.

Source files
------------

// File: rtl/aes_round_sequencer_pkg.sv
// aes_round_sequencer_pkg: shared AES-128 types, round count, FSM encoding, S-box and GF(2^8) helpers
package aes_round_sequencer_pkg;
  localparam int NR = 10;
  localparam int KADDR_W = 4;
  typedef logic [7:0] byte_t;
  // Byte 0 is the most significant byte of the flat block; state[r][c] lives at index 4c+r
  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, ROUND, OUT} fsm_t;
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic blk_t to_blk(logic [127:0] flat);
    return blk_t'(flat);
  endfunction
endpackage

// File: rtl/aes_round_sequencer_cipher_round.sv
// aes_round_sequencer_cipher_round: one combinational AES round, SubBytes->ShiftRows->MixColumns (skipped on last)->AddRoundKey
module aes_round_sequencer_cipher_round
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] key,
  input  logic         last,
  output logic [127:0] res
);
  blk_t s, sb, sr, mc;
  always_comb begin
    s = to_blk(st);
    for (int i = 0; i < 16; i++) sb[i] = SBOX[s[i]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    res = (last ? sr : mc) ^ key;
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 controller, one round per clock; optional abort via AES_ROUND_SEQUENCER_ABORT_EN
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic [KADDR_W-1:0] key_addr,
  input  logic [127:0]       key_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy
`ifdef AES_ROUND_SEQUENCER_ABORT_EN
  ,
  input  logic               abort
`endif
);
  fsm_t state, nxt;
  logic [KADDR_W-1:0] rnd;
  logic [127:0] st, rnd_out;
  logic fire, last, kill;
  assign fire = in_valid && in_ready;
  assign last = rnd == KADDR_W'(NR);
`ifdef AES_ROUND_SEQUENCER_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  aes_round_sequencer_cipher_round u_cipher_round (
    .st(st), .key(key_data), .last(last), .res(rnd_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd <= '0;
      st <= '0;
    end else begin
      state <= nxt;
      if (kill) begin
        rnd <= '0;
        st <= '0;
      end else if (state == IDLE && fire) begin
        st <= in_data ^ key_data;
        rnd <= KADDR_W'(1);
      end else if (state == ROUND) begin
        st <= rnd_out;
        if (!last) rnd <= rnd + KADDR_W'(1);
      end
    end
  end
  always_comb begin
    nxt = kill ? IDLE :
          state == IDLE  ? (fire ? ROUND : IDLE) :
          state == ROUND ? (last ? OUT : ROUND) :
          (out_ready ? IDLE : OUT);
  end
  // The ROM registers key_addr, so the address driven now is the key consumed next cycle
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == OUT;
    busy = state == ROUND || state == OUT;
    out_data = out_valid ? st : '0;
    key_addr = (rst || kill) ? '0 :
               state == IDLE ? (fire ? KADDR_W'(1) : '0) :
               (state == ROUND && !last) ? rnd + KADDR_W'(1) : '0;
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed FIPS-197 vectors against aes_round_sequencer with a 1-cycle key ROM model
module tb_aes_round_sequencer;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [127:0] in_data = '0, key_data, out_data;
  logic [3:0] key_addr;
  logic [127:0] rom [16];
  int checks = 0, errors = 0;
`ifdef AES_ROUND_SEQUENCER_ABORT_EN
  logic abort = 1'b0;
`endif
  always #5 clk = ~clk;
  always_ff @(posedge clk) key_data <= rom[key_addr];
  aes_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_addr(key_addr), .key_data(key_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
`ifdef AES_ROUND_SEQUENCER_ABORT_EN
    , .abort(abort)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box from first principles: inverse x^254 in GF(2^8), then the affine map
  function automatic logic [7:0] sbx(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gm(r, r);
      if (i != 0) r = gm(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbx(t[31:24]), sbx(t[23:16]), sbx(t[15:8]), sbx(t[7:0])} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rom[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [127:0] pt);
    in_data = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input bit ka);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      if (ka) chk("key_addr_round", 128'(key_addr), 128'(lat < 10 ? lat + 1 : 0));
      tick();
      lat++;
    end
    chk("latency", 128'(lat), 128'(11));
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", 128'(out_valid), 128'(0));
    chk("rel_in_ready", 128'(in_ready), 128'(1));
    chk("rel_out_data", out_data, '0);
  endtask
  initial begin
    int t, t1, t2, n;
    load_key(KEY_B);
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_key_addr", 128'(key_addr), 128'(0));
    chk("rst_out_data", out_data, '0);
    rst = 1'b0;
    tick();
    // App.B vector
    accept(PT_B);
    wait_out(1'b0);
    chk("b_data", out_data, CT_B);
    chk("b_in_ready", 128'(in_ready), 128'(0));
    chk("b_busy", 128'(busy), 128'(1));
    release_out();
    // App.C.1 with per-cycle key address sequence
    load_key(KEY_C);
    tick();
    chk("c_ka_idle", 128'(key_addr), 128'(0));
    in_data = PT_C;
    in_valid = 1'b1;
    #1;
    chk("c_ka_accept", 128'(key_addr), 128'(1));
    tick();
    in_valid = 1'b0;
    wait_out(1'b1);
    chk("c_ka_out", 128'(key_addr), 128'(0));
    chk("c_data", out_data, CT_C);
    release_out();
    // Backpressure with a competing offer
    accept(PT_C);
    wait_out(1'b0);
    in_data = PT_B;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data", out_data, CT_C);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_busy", 128'(busy), 128'(0));
    // Back-to-back blocks
    load_key(KEY_B);
    tick();
    in_data = PT_B;
    in_valid = 1'b1;
    out_ready = 1'b1;
    t = 0; t1 = 0; t2 = 0; n = 0;
    while (n < 2 && t < 60) begin
      tick();
      t++;
      if (out_valid) begin
        chk("b2b_data", out_data, CT_B);
        if (n == 0) t1 = t; else t2 = t;
        n++;
        if (n == 2) in_valid = 1'b0;
      end
    end
    chk("b2b_count", 128'(n), 128'(2));
    chk("b2b_first", 128'(t1), 128'(11));
    chk("b2b_spacing", 128'(t2 - t1), 128'(12));
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", 128'(in_ready), 128'(1));
    // Reset at round 5, then a clean block
    accept(PT_B);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("mr_in_ready", 128'(in_ready), 128'(1));
    chk("mr_out_valid", 128'(out_valid), 128'(0));
    chk("mr_busy", 128'(busy), 128'(0));
    chk("mr_key_addr", 128'(key_addr), 128'(0));
    chk("mr_out_data", out_data, '0);
    rst = 1'b0;
    tick();
    accept(PT_B);
    wait_out(1'b0);
    chk("mr_data", out_data, CT_B);
    release_out();
`ifdef AES_ROUND_SEQUENCER_ABORT_EN
    accept(PT_B);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_in_ready", 128'(in_ready), 128'(1));
    chk("ab_busy", 128'(busy), 128'(0));
    chk("ab_key_addr", 128'(key_addr), 128'(0));
    n = 0;
    repeat (15) begin
      tick();
      if (out_valid) n++;
    end
    chk("ab_no_output", 128'(n), 128'(0));
    abort = 1'b1;
    accept(PT_B);
    abort = 1'b0;
    chk("ab_idle_ignored", 128'(busy), 128'(1));
    wait_out(1'b0);
    chk("ab_data", out_data, CT_B);
    release_out();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
